output_dev_mc: RTL

- Parametrised successor to the single-register output device.
- NCH memory-mapped 32-bit output channels plus one control register. Write, registered readback and byte-lane writes are all on the CPU store/load path.
- Includes a multiplexed 8-digit hex scanner that continuously displays one selected channel on the board's seven-segment display.
- Sits on the CPU data bus beside data memory; selected by the address decoder through en.

---
 rtl/output_dev_mc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/output_dev_mc.sv
// output_dev_mc: NCH memory-mapped 32-bit output channels, a control register and an
// 8-digit multiplexed hex scanner. Optional macro OPD_BLINK_EN makes ctrl[6] blink the display per frame.
module output_dev_mc #(
    parameter int          NCH      = 4,
    parameter int          ADDR_W   = 3,
    parameter int          SCAN_DIV = 16,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic [32*NCH-1:0] ch_out,
    output logic [7:0]        seg_an,
    output logic [3:0]        seg_hex
);
    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [ADDR_W-1:0] CTRL_IDX = ADDR_W'(NCH);

    logic [31:0]      ch_r     [NCH];
    logic [31:0]      ch_nxt_s [NCH];
    logic [7:0]       ctrl_r;
    logic [7:0]       ctrl_nxt_s;
    logic [31:0]      dout_r;
    logic [31:0]      rd_s;
    logic [31:0]      sel_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [2:0]       digit_r;
    logic [2:0]       digit_nxt_s;
    logic [7:0]       seg_an_r;
    logic [7:0]       seg_an_nxt_s;
    logic [3:0]       seg_hex_r;
    logic [3:0]       seg_hex_nxt_s;
    logic             blank_s;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = lanes[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Next-state of the register file; reads and the scanner see these values (write-first)
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                ch_nxt_s[i] = merge_lanes(ch_r[i], din, be);
            end else begin
                ch_nxt_s[i] = ch_r[i];
            end
        end
        if (en && (addr == CTRL_IDX) && be[0]) begin
            ctrl_nxt_s = din[7:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
    end

    // Read-data mux and displayed-channel mux; out-of-range indices yield zero
    always_comb begin
        rd_s  = (addr == CTRL_IDX) ? {24'h00_0000, ctrl_nxt_s} : 32'h0000_0000;
        sel_s = 32'h0000_0000;
        for (int i = 0; i < NCH; i++) begin
            rd_s  = rd_s  | ((addr == ADDR_W'(i)) ? ch_nxt_s[i] : 32'h0000_0000);
            sel_s = sel_s | ((ctrl_nxt_s[ADDR_W-1:0] == ADDR_W'(i)) ? ch_nxt_s[i] : 32'h0000_0000);
        end
    end

    // Scan divider and digit index advance
    always_comb begin
        if (div_r == DIV_LAST) begin
            div_nxt_s   = '0;
            digit_nxt_s = digit_r + 3'd1;
        end else begin
            div_nxt_s   = div_r + DIV_W'(1);
            digit_nxt_s = digit_r;
        end
    end

`ifdef OPD_BLINK_EN
    logic frame_r;
    logic frame_nxt_s;

    // Frame bit flips each time the digit index wraps 7 -> 0
    always_comb begin
        if ((div_r == DIV_LAST) && (digit_r == 3'd7)) begin
            frame_nxt_s = ~frame_r;
        end else begin
            frame_nxt_s = frame_r;
        end
    end

    // Frame bit register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_r <= 1'b0;
        end else begin
            frame_r <= frame_nxt_s;
        end
    end

    assign blank_s = ctrl_nxt_s[7] | (ctrl_nxt_s[6] & frame_nxt_s);
`else
    assign blank_s = ctrl_nxt_s[7];
`endif

    // Display outputs for the digit that will be active after this edge
    always_comb begin
        seg_an_nxt_s  = blank_s ? 8'hFF : ~(8'h01 << digit_nxt_s);
        seg_hex_nxt_s = sel_s[{digit_nxt_s, 2'b00} +: 4];
    end

    // Channel, control, read-data and scanner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                ch_r[i] <= RST_VAL;
            end
            ctrl_r    <= 8'h00;
            dout_r    <= 32'h0000_0000;
            div_r     <= '0;
            digit_r   <= 3'd0;
            seg_an_r  <= 8'hFE;
            seg_hex_r <= RST_VAL[3:0];
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ch_r[i] <= ch_nxt_s[i];
            end
            ctrl_r    <= ctrl_nxt_s;
            dout_r    <= rd_s;
            div_r     <= div_nxt_s;
            digit_r   <= digit_nxt_s;
            seg_an_r  <= seg_an_nxt_s;
            seg_hex_r <= seg_hex_nxt_s;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch_out
        assign ch_out[32*g +: 32] = ch_r[g];
    end

    assign dout    = dout_r;
    assign seg_an  = seg_an_r;
    assign seg_hex = seg_hex_r;

endmodule
